// File: rtl/gon_bus_if.sv
// rtl/gon_bus_if.sv - source/GLB handshake bundle for the global output network
interface gon_bus_if #(
  parameter int DATA_BITWIDTH = 16,
  parameter int SLV_NUM       = 6,
  parameter int FIFO_PTR_BW   = 2
);
  logic [SLV_NUM*DATA_BITWIDTH-1:0] i_data;
  logic [SLV_NUM-1:0]               i_valid;
  logic [SLV_NUM-1:0]               o_ready;
  logic                             i_ready;
  logic                             o_valid;
  logic [DATA_BITWIDTH-1:0]         o_data;
  logic [2:0]                       o_tag;
  logic [FIFO_PTR_BW:0]             o_count;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_valid, o_data, o_tag, o_count
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_valid, o_data, o_tag, o_count
  );
endinterface

// File: rtl/gon_bus.sv
// rtl/gon_bus.sv - round-robin PE-row collector into an FWFT FIFO toward the GLB (optional GON_STALL_CNT_EN)
module gon_bus #(
  parameter int DATA_BITWIDTH = 16,
  parameter int SLV_NUM       = 6,
  parameter int FIFO_PTR_BW   = 2
) (
  input  logic      i_clk,
  input  logic      i_rst,
  gon_bus_if.slave  bus
`ifdef GON_STALL_CNT_EN
  ,
  output logic [15:0] o_stall_cnt
`endif
);

  localparam int DEPTH = 1 << FIFO_PTR_BW;
  localparam logic [FIFO_PTR_BW:0] DEPTH_C = {1'b1, {FIFO_PTR_BW{1'b0}}};

  logic [2:0]               last_grant_q;
  logic [FIFO_PTR_BW-1:0]   wr_ptr_q;
  logic [FIFO_PTR_BW-1:0]   rd_ptr_q;
  logic [FIFO_PTR_BW:0]     count_q;
  logic [FIFO_PTR_BW:0]     count_d;
  logic [DATA_BITWIDTH-1:0] data_mem_q [DEPTH];
  logic [2:0]               tag_mem_q  [DEPTH];

  logic [SLV_NUM-1:0]       grant;
  logic [2:0]               grant_id;
  logic [2:0]               scan_idx;
  logic                     found;
  logic [DATA_BITWIDTH-1:0] grant_data;
  logic                     full;
  logic                     push;
  logic                     pop;

  // Full is judged on the registered count only, so a pop never frees a slot in the same cycle
  assign full = (count_q == DEPTH_C);

  // Round-robin scan starting just after the previous winner; held off while full or in reset
  always_comb begin
    grant    = '0;
    grant_id = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (!i_rst && !full) begin
      for (int j = 1; j <= SLV_NUM; j++) begin
        scan_idx = 3'((int'(last_grant_q) + j) % SLV_NUM);
        if (!found && bus.i_valid[scan_idx]) begin
          found           = 1'b1;
          grant_id        = scan_idx;
          grant[scan_idx] = 1'b1;
        end
      end
    end
  end

  assign grant_data = DATA_BITWIDTH'(bus.i_data >> (DATA_BITWIDTH * int'(grant_id)));
  assign push       = |(bus.i_valid & grant);
  assign pop        = (count_q != '0) && bus.i_ready;

  // Occupancy next state: push and pop together leave the count unchanged
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage, pointers, occupancy and round-robin history
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      last_grant_q <= 3'(SLV_NUM - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int e = 0; e < DEPTH; e++) begin
        data_mem_q[e] <= '0;
        tag_mem_q[e]  <= '0;
      end
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= grant_data;
        tag_mem_q[wr_ptr_q]  <= grant_id;
        wr_ptr_q             <= wr_ptr_q + 1'b1;
        last_grant_q         <= grant_id;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign bus.o_ready = grant;
  assign bus.o_valid = (count_q != '0);
  assign bus.o_data  = data_mem_q[rd_ptr_q];
  assign bus.o_tag   = tag_mem_q[rd_ptr_q];
  assign bus.o_count = count_q;

`ifdef GON_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Saturating count of cycles where some source is waiting on a full FIFO
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_cnt_q <= '0;
    end else if ((|bus.i_valid) && full && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_gon_bus.sv
// tb/tb_gon_bus.sv - vector table, directed corners and randomized model check for gon_bus
module tb_gon_bus;
  localparam int DW    = 16;
  localparam int SN    = 6;
  localparam int PB    = 2;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  gon_bus_if #(.DATA_BITWIDTH(DW), .SLV_NUM(SN), .FIFO_PTR_BW(PB)) bus ();

`ifdef GON_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  gon_bus #(.DATA_BITWIDTH(DW), .SLV_NUM(SN), .FIFO_PTR_BW(PB)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
`ifdef GON_STALL_CNT_EN
    ,
    .o_stall_cnt(stall_cnt)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model: queue of {tag,data} ----------------
  typedef struct packed {
    logic [2:0]    tag;
    logic [DW-1:0] data;
  } entry_t;

  entry_t mq[$];
  int     m_last;
  int     m_stall;

  task automatic model_reset();
    mq.delete();
    m_last  = SN - 1;
    m_stall = 0;
  endtask

  function automatic logic [SN-1:0] model_ready(input logic [SN-1:0] v);
    logic [SN-1:0] r;
    r = '0;
    if (mq.size() < DEPTH) begin
      for (int j = 1; j <= SN; j++) begin
        int k;
        k = (m_last + j) % SN;
        if (v[k]) begin
          r[k] = 1'b1;
          break;
        end
      end
    end
    return r;
  endfunction

  // Called at posedge+1 with inputs set; checks, advances the model, moves to next posedge+1
  task automatic step(input string nm, output logic [SN-1:0] g);
    logic [SN-1:0] er;
    int            sz;
    #1;
    er = model_ready(bus.i_valid);
    sz = mq.size();
    check({nm, " ready"}, 32'(bus.o_ready), 32'(er));
    check({nm, " valid"}, 32'(bus.o_valid), 32'(sz != 0));
    check({nm, " count"}, 32'(bus.o_count), 32'(sz));
    if (sz != 0) begin
      check({nm, " data"}, 32'(bus.o_data), 32'(mq[0].data));
      check({nm, " tag"},  32'(bus.o_tag),  32'(mq[0].tag));
    end
`ifdef GON_STALL_CNT_EN
    check({nm, " stall"}, 32'(stall_cnt), 32'(m_stall));
    if ((|bus.i_valid) && sz == DEPTH && m_stall < 65535) m_stall++;
`endif
    if (sz != 0 && bus.i_ready) void'(mq.pop_front());
    g = er & bus.i_valid;
    for (int k = 0; k < SN; k++) begin
      if (g[k]) begin
        entry_t e;
        e.tag  = 3'(k);
        e.data = bus.i_data[k*DW +: DW];
        mq.push_back(e);
        m_last = k;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.i_valid = '1;
    bus.i_data  = {SN{16'h5A5A}};
    bus.i_ready = 1'b0;
    rst = 1'b1;
    #1;
    check("rst ready", 32'(bus.o_ready), 32'(0));
    check("rst valid", 32'(bus.o_valid), 32'(0));
    check("rst count", 32'(bus.o_count), 32'(0));
    check("rst data",  32'(bus.o_data),  32'(0));
    check("rst tag",   32'(bus.o_tag),   32'(0));
`ifdef GON_STALL_CNT_EN
    check("rst stall", 32'(stall_cnt), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_valid = '0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit               do_rst;
    logic [SN-1:0]    valid;
    logic [SN*DW-1:0] data;
    bit               ready;
    logic [SN-1:0]    e_ready;
    bit               e_valid;
    logic [DW-1:0]    e_data;
    logic [2:0]       e_tag;
    logic [2:0]       e_count;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit r, logic [SN-1:0] v, logic [SN*DW-1:0] d, bit rd,
                              logic [SN-1:0] er, bit ev, logic [DW-1:0] ed,
                              logic [2:0] et, logic [2:0] ec);
    vec_t x;
    x.do_rst = r;  x.valid = v;    x.data = d;     x.ready = rd;
    x.e_ready = er; x.e_valid = ev; x.e_data = ed; x.e_tag = et; x.e_count = ec;
    return x;
  endfunction

  task automatic apply_row(input vec_t r, input int idx);
    string s;
    if (r.do_rst) do_reset();
    bus.i_valid = r.valid;
    bus.i_data  = r.data;
    bus.i_ready = r.ready;
    #1;
    s = $sformatf("row%0d", idx);
    check({s, " ready"}, 32'(bus.o_ready), 32'(r.e_ready));
    check({s, " valid"}, 32'(bus.o_valid), 32'(r.e_valid));
    check({s, " count"}, 32'(bus.o_count), 32'(r.e_count));
    if (r.e_valid) begin
      check({s, " data"}, 32'(bus.o_data), 32'(r.e_data));
      check({s, " tag"},  32'(bus.o_tag),  32'(r.e_tag));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [SN*DW-1:0] d_single;
    logic [SN*DW-1:0] d_rr;
    logic [SN-1:0]    g;
    logic             pend [SN];
    logic [DW-1:0]    word [SN];

    bus.i_valid = '0;
    bus.i_data  = '0;
    bus.i_ready = 1'b0;
    model_reset();

    d_single = '0;
    d_single[2*DW +: DW] = 16'h00A5;
    for (int k = 0; k < SN; k++) d_rr[k*DW +: DW] = 16'h0010 + 16'(k);

    // single source, then idle with GLB ready (empty pop)
    tbl.push_back(mk(1, 6'b000100, d_single, 1, 6'b000100, 0, 16'h0, 3'd0, 3'd0));
    tbl.push_back(mk(0, 6'b000000, d_single, 1, 6'b000000, 1, 16'h00A5, 3'd2, 3'd1));
    tbl.push_back(mk(0, 6'b000000, d_single, 1, 6'b000000, 0, 16'h0, 3'd0, 3'd0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 6'b000000, d_single, 1, 6'b000000, 0, 16'h0, 3'd0, 3'd0));
    // round robin over all six sources, one word per cycle
    for (int i = 0; i < 7; i++) begin
      if (i == 0)
        tbl.push_back(mk(1, 6'b111111, d_rr, 1, 6'b000001, 0, 16'h0, 3'd0, 3'd0));
      else
        tbl.push_back(mk(0, 6'b111111, d_rr, 1, 6'(1 << (i % SN)), 1,
                         16'h0010 + 16'((i - 1) % SN), 3'((i - 1) % SN), 3'd1));
    end
    tbl.push_back(mk(0, 6'b000000, d_rr, 1, 6'b000000, 1, 16'h0010, 3'd0, 3'd1));
    tbl.push_back(mk(0, 6'b000000, d_rr, 1, 6'b000000, 0, 16'h0, 3'd0, 3'd0));

    for (int i = 0; i < tbl.size(); i++) apply_row(tbl[i], i);

    // full / backpressure, then drain in accept order
    do_reset();
    bus.i_ready = 1'b0;
    bus.i_data  = '0;
    bus.i_data[0*DW +: DW] = 16'h00A0;
    bus.i_data[1*DW +: DW] = 16'h00B1;
    bus.i_valid = 6'b000011;
    repeat (6) step("full", g);
    check("full count", 32'(bus.o_count), 32'(4));
    check("full ready", 32'(bus.o_ready), 32'(0));
    check("full head data", 32'(bus.o_data), 32'(16'h00A0));
`ifdef GON_STALL_CNT_EN
    check("full stall", 32'(stall_cnt), 32'(2));
`endif
    bus.i_ready = 1'b1;
    check("full ready with glb ready", 32'(bus.o_ready), 32'(0));
    bus.i_valid = '0;
    repeat (5) step("drain", g);

    // push and pop together across pointer wrap
    do_reset();
    bus.i_data  = '0;
    bus.i_valid = 6'b001000;
    bus.i_data[3*DW +: DW] = 16'h0300;
    step("wrap fill", g);
    bus.i_data[3*DW +: DW] = 16'h0301;
    step("wrap fill", g);
    bus.i_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.i_data[3*DW +: DW] = 16'h0302 + 16'(i);
      step("wrap", g);
      check("wrap count", 32'(bus.o_count), 32'(2));
    end
    bus.i_valid = '0;
    repeat (3) step("wrap drain", g);

    // asynchronous reset in the middle of a cycle
    do_reset();
    bus.i_data  = '0;
    bus.i_data[0*DW +: DW] = 16'h0055;
    bus.i_valid = 6'b000001;
    repeat (3) step("arst fill", g);
    check("arst pre count", 32'(bus.o_count), 32'(3));
    #2;
    rst = 1'b1;
    #1;
    check("arst valid", 32'(bus.o_valid), 32'(0));
    check("arst count", 32'(bus.o_count), 32'(0));
    check("arst ready", 32'(bus.o_ready), 32'(0));
    bus.i_valid = 6'b000110;
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check("arst first grant", 32'(bus.o_ready), 32'(6'b000010));
    step("arst after", g);
    bus.i_valid = '0;
    bus.i_ready = 1'b1;
    repeat (2) step("arst drain", g);

    // randomized traffic; sources hold valid/data until granted
    do_reset();
    for (int k = 0; k < SN; k++) begin
      pend[k] = 1'b0;
      word[k] = '0;
    end
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < SN; k++) begin
        if (!pend[k] && $urandom_range(0, 2) == 0) begin
          pend[k] = 1'b1;
          word[k] = 16'($urandom);
        end
        bus.i_valid[k]         = pend[k];
        bus.i_data[k*DW +: DW] = word[k];
      end
      bus.i_ready = ((c / 50) % 2 == 1) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
      step("rand", g);
      for (int k = 0; k < SN; k++) if (g[k]) pend[k] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
